symmetry_stats_tracker: RTL and testbench
=========================================

# symmetry_stats_tracker

Sequential statistics stage directly downstream of the combinational symmetry detector. Each cycle it can accept one detector result (symmetric flag plus 3-bit mismatch count) under a valid strobe. It keeps saturating event counters, current and longest runs of symmetric words, and a sliding-window mismatch sum with a threshold alarm. All results are registered for readout by the top-level wrapper.

## Interface
Parameters:
- CNT_W, 8: width of every event/run counter.
- WINDOW, 16: number of most recent accepted samples in the sliding mismatch window; power of two, 2..64.
- ALARM_THRESH, 24: alarm asserts when win_sum >= this value; range 1..4*WINDOW.
- SUM_W, derived $clog2(4*WINDOW+1): width of win_sum; not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all state; wins over in_valid.
- in_valid  in  1  sample strobe; one sample accepted per cycle while high.
- in_sym  in  1  detector symmetric flag.
- in_mismatch  in  3  detector mismatch count; legal 0..4.
- total_cnt  out  CNT_W  accepted samples, saturating.
- sym_cnt  out  CNT_W  accepted samples with in_sym=1, saturating.
- run_len  out  CNT_W  current run of consecutive symmetric samples, saturating.
- max_run  out  CNT_W  largest run_len since reset/clear.
- win_sum  out  SUM_W  sum of the mismatch counts of the last WINDOW accepted samples.
- win_full  out  1  WINDOW samples accepted since reset/clear.
- alarm  out  1  win_sum >= ALARM_THRESH.
- err  out  1  sticky input-consistency error (see Configuration).

## Operation
- Reset: every output and all internal state go to 0, including the window buffer.
- clear=1: same effect as reset, applied at the clock edge. Any in_valid in the same cycle is dropped.
- Accepted sample (in_valid=1, clear=0):
  - total_cnt increments; it holds at 2^CNT_W-1.
  - If in_sym=1: sym_cnt increments (saturating) and run_len increments (saturating).
  - If in_sym=0: run_len becomes 0.
  - max_run takes max(max_run, next run_len).
- Mismatch clamp: in_mismatch values 5..7 are clamped to 4 before use.
- Window:
  - Circular buffer of WINDOW 3-bit entries with write pointer wp.
  - next win_sum = win_sum + m_new − buf[wp]; then buf[wp] ← m_new and wp advances.
  - Unfilled entries read as 0, so win_sum equals the partial sum before the window fills.
  - wp wraps from WINDOW−1 to 0.
  - win_full sets when the WINDOW-th sample is accepted and stays set until reset/clear.
- alarm is registered from the next win_sum value, so it is never a cycle behind win_sum.
- in_valid=0: all state holds.

## Timing
- Latency is 1 cycle: a sample accepted at edge N is reflected in all outputs after edge N.
- Back-to-back samples are supported every cycle with no stall; no ready signal.
- Asynchronous reset asserted mid-stream discards the in-flight sample.
- Release of reset is synchronized by the top level.

## Configuration
- SYM_STATS_CHECK_EN defined: on an accepted sample, err sets and stays set until reset/clear if either condition holds:
  - in_sym != (in_mismatch==0)
  - in_mismatch > 4
- SYM_STATS_CHECK_EN undefined: err is tied to 0 and no check logic is built.
- Clamping happens in both builds.

## Structure
- Shared package symmetry_pkg holds:
  - MISMATCH_W=3 and MISMATCH_MAX=4.
  - A packed struct typedef sym_result_t {logic sym; logic [2:0] mismatch}, shared with the detector wrapper.
- One sub-module, sat_counter, parameterised by width, with inc, clr and zero inputs. It is instantiated for total_cnt, sym_cnt and run_len.
- The window buffer and running sum stay in the top module.

## Test plan
- Reset with outputs checked, then 20 consecutive samples (sym=1, mm=0) -> total_cnt=20, sym_cnt=20, run_len=20, max_run=20, win_sum=0, win_full=1 after the 16th sample.
- Run of 5 symmetric samples, 1 sample (sym=0, mm=2), then 3 symmetric -> run_len=3, max_run=5, win_sum=2.
- 16 samples with mm=2 then 4 with mm=0 (defaults) -> win_sum=32 with alarm=1 from the 12th sample (sum 24); then win_sum 30, 28, 26, 24 with alarm staying 1; one more mm=0 -> 22 and alarm=0.
- 300 symmetric samples with CNT_W=8 -> total_cnt, sym_cnt and run_len all hold at 255.
- clear and in_valid asserted together after 10 samples -> all outputs 0 next cycle and the sample is not counted. rst_n pulsed low mid-cycle -> outputs 0 immediately.
- With SYM_STATS_CHECK_EN: sample (sym=1, mm=1) -> err=1 and stays 1. Sample mm=7 -> contributes 4 to win_sum. Without the macro: err stays 0.

Source files
------------

// File: rtl/symmetry_stats_tracker_pkg.sv
// Shared detector result types and mismatch constants for the symmetry
// detector wrapper and its statistics stage.
package symmetry_pkg;

  localparam int MISMATCH_W = 3;
  localparam logic [MISMATCH_W-1:0] MISMATCH_MAX = 3'd4;

  typedef struct packed {
    logic                  sym;
    logic [MISMATCH_W-1:0] mismatch;
  } sym_result_t;

  // Encodings 5..7 cannot come from a 4-position compare; treat them as worst case.
  function automatic logic [MISMATCH_W-1:0] clamp_mismatch(input logic [MISMATCH_W-1:0] m);
    return (m > MISMATCH_MAX) ? MISMATCH_MAX : m;
  endfunction

endpackage

// File: rtl/symmetry_stats_tracker_if.sv
// Sample/clear inputs and registered statistics outputs of the tracker;
// master drives samples, slave is the tracker.
interface symmetry_stats_tracker_if #(
  parameter int CNT_W = 8,
  parameter int SUM_W = 7
);
  import symmetry_pkg::*;

  logic                  clear;
  logic                  in_valid;
  logic                  in_sym;
  logic [MISMATCH_W-1:0] in_mismatch;
  logic [CNT_W-1:0]      total_cnt;
  logic [CNT_W-1:0]      sym_cnt;
  logic [CNT_W-1:0]      run_len;
  logic [CNT_W-1:0]      max_run;
  logic [SUM_W-1:0]      win_sum;
  logic                  win_full;
  logic                  alarm;
  logic                  err;

  modport master (
    output clear, in_valid, in_sym, in_mismatch,
    input  total_cnt, sym_cnt, run_len, max_run, win_sum, win_full, alarm, err
  );

  modport slave (
    input  clear, in_valid, in_sym, in_mismatch,
    output total_cnt, sym_cnt, run_len, max_run, win_sum, win_full, alarm, err
  );

endinterface

// File: rtl/symmetry_stats_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear and zero; clear/zero win over
// increment, and the count holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  input  logic             i_zero,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || i_zero) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/symmetry_stats_tracker.sv
// Event counters, symmetric run tracking and sliding-window mismatch sum with alarm,
// one-cycle latency, no stall. Define SYM_STATS_CHECK_EN to build the sticky err check.
module symmetry_stats_tracker
  import symmetry_pkg::*;
#(
  parameter  int CNT_W        = 8,
  parameter  int WINDOW       = 16,
  parameter  int ALARM_THRESH = 24,
  localparam int SUM_W        = $clog2(4*WINDOW+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  symmetry_stats_tracker_if.slave  s
);

  localparam int                WP_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WP_W-1:0]   WP_LAST = WP_W'(WINDOW-1);
  localparam logic [SUM_W-1:0]  THRESH = SUM_W'(ALARM_THRESH);

  sym_result_t           w_res;
  logic                  w_acc;
  logic [MISMATCH_W-1:0] w_mm;
  logic [CNT_W-1:0]      w_run;
  logic [SUM_W-1:0]      w_sum_nxt;

  logic [MISMATCH_W-1:0] r_buf [WINDOW];
  logic [WP_W-1:0]       r_wp;
  logic [SUM_W-1:0]      r_sum;
  logic                  r_full;
  logic                  r_alarm;
  logic [CNT_W-1:0]      r_max;

  assign w_res = '{sym: s.in_sym, mismatch: s.in_mismatch};
  assign w_acc = s.in_valid & ~s.clear;
  assign w_mm  = clamp_mismatch(w_res.mismatch);

  sat_counter #(.WIDTH(CNT_W)) u_total (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_acc),
    .i_clr  (s.clear),
    .i_zero (1'b0),
    .o_cnt  (s.total_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_sym (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_acc & w_res.sym),
    .i_clr  (s.clear),
    .i_zero (1'b0),
    .o_cnt  (s.sym_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_run (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_acc & w_res.sym),
    .i_clr  (s.clear),
    .i_zero (w_acc & ~w_res.sym),
    .o_cnt  (w_run)
  );

  // run_len never exceeds max_run, so max_run only moves when the run is at the record and grows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max <= '0;
    end else if (s.clear) begin
      r_max <= '0;
    end else if (w_acc && w_res.sym && (w_run == r_max) && (r_max != '1)) begin
      r_max <= r_max + 1'b1;
    end
  end

  assign w_sum_nxt = r_sum + SUM_W'(w_mm) - SUM_W'(r_buf[r_wp]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WINDOW; i++) r_buf[i] <= '0;
      r_wp    <= '0;
      r_sum   <= '0;
      r_full  <= 1'b0;
      r_alarm <= 1'b0;
    end else if (s.clear) begin
      for (int i = 0; i < WINDOW; i++) r_buf[i] <= '0;
      r_wp    <= '0;
      r_sum   <= '0;
      r_full  <= 1'b0;
      r_alarm <= 1'b0;
    end else if (w_acc) begin
      r_buf[r_wp] <= w_mm;
      r_wp        <= (r_wp == WP_LAST) ? '0 : r_wp + 1'b1;
      r_sum       <= w_sum_nxt;
      r_alarm     <= (w_sum_nxt >= THRESH);
      if (r_wp == WP_LAST) r_full <= 1'b1;
    end
  end

`ifdef SYM_STATS_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (s.clear) begin
      r_err <= 1'b0;
    end else if (w_acc && ((w_res.sym != (w_res.mismatch == '0)) ||
                           (w_res.mismatch > MISMATCH_MAX))) begin
      r_err <= 1'b1;
    end
  end

  assign s.err = r_err;
`else
  assign s.err = 1'b0;
`endif

  assign s.run_len  = w_run;
  assign s.max_run  = r_max;
  assign s.win_sum  = r_sum;
  assign s.win_full = r_full;
  assign s.alarm    = r_alarm;

endmodule

// File: tb/tb_symmetry_stats_tracker.sv
// Directed bench for symmetry_stats_tracker: the driver queues hand-derived
// expectations, a negedge monitor compares them against the outputs.
module tb_symmetry_stats_tracker;
  import symmetry_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  symmetry_stats_tracker_if #(.CNT_W(8), .SUM_W(7)) bus ();

  symmetry_stats_tracker #(.CNT_W(8), .WINDOW(16), .ALARM_THRESH(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus)
  );

`ifdef SYM_STATS_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  typedef struct packed {
    logic [7:0] tot;
    logic [7:0] sy;
    logic [7:0] run;
    logic [7:0] mx;
    logic [6:0] sum;
    logic       full;
    logic       alarm;
    logic       err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic cmp(input string nm, input string fld, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, expv);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      cmp(nm, "total_cnt", int'(bus.total_cnt), int'(e.tot));
      cmp(nm, "sym_cnt",   int'(bus.sym_cnt),   int'(e.sy));
      cmp(nm, "run_len",   int'(bus.run_len),   int'(e.run));
      cmp(nm, "max_run",   int'(bus.max_run),   int'(e.mx));
      cmp(nm, "win_sum",   int'(bus.win_sum),   int'(e.sum));
      cmp(nm, "win_full",  int'(bus.win_full),  int'(e.full));
      cmp(nm, "alarm",     int'(bus.alarm),     int'(e.alarm));
      cmp(nm, "err",       int'(bus.err),       int'(e.err));
    end
  end

  task automatic chk(input string nm, input int tot, input int sy, input int run, input int mx,
                     input int sum, input int full, input int alarm, input int err);
    exp_t e;
    e.tot   = 8'(tot);
    e.sy    = 8'(sy);
    e.run   = 8'(run);
    e.mx    = 8'(mx);
    e.sum   = 7'(sum);
    e.full  = 1'(full);
    e.alarm = 1'(alarm);
    e.err   = 1'(err);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic smp(input bit v, input bit sy, input logic [2:0] m, input bit c);
    @(negedge clk);
    bus.in_valid    = v;
    bus.in_sym      = sy;
    bus.in_mismatch = m;
    bus.clear       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n, input bit sy, input logic [2:0] m);
    repeat (n) smp(1'b1, sy, m, 1'b0);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $finish;
  end

  initial begin
    bus.clear       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_sym      = 1'b0;
    bus.in_mismatch = 3'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Long symmetric run: window fills on the 16th sample.
    run_n(15, 1'b1, 3'd0);
    chk("fill15", 15, 15, 15, 15, 0, 0, 0, 0);
    run_n(1, 1'b1, 3'd0);
    chk("fill16", 16, 16, 16, 16, 0, 1, 0, 0);
    run_n(4, 1'b1, 3'd0);
    chk("fill20", 20, 20, 20, 20, 0, 1, 0, 0);

    smp(1'b1, 1'b1, 3'd0, 1'b1);
    chk("clr_a", 0, 0, 0, 0, 0, 0, 0, 0);

    // Broken run keeps the earlier record.
    run_n(5, 1'b1, 3'd0);
    smp(1'b1, 1'b0, 3'd2, 1'b0);
    chk("break", 6, 5, 0, 5, 2, 0, 0, 0);
    run_n(3, 1'b1, 3'd0);
    chk("run3", 9, 8, 3, 5, 2, 0, 0, 0);
    smp(1'b0, 1'b1, 3'd4, 1'b0);
    chk("hold", 9, 8, 3, 5, 2, 0, 0, 0);

    smp(1'b1, 1'b1, 3'd0, 1'b1);
    chk("clr_b", 0, 0, 0, 0, 0, 0, 0, 0);

    // Window sum and alarm threshold crossing in both directions.
    run_n(11, 1'b0, 3'd2);
    chk("mm11", 11, 0, 0, 0, 22, 0, 0, 0);
    run_n(1, 1'b0, 3'd2);
    chk("mm12", 12, 0, 0, 0, 24, 0, 1, 0);
    run_n(4, 1'b0, 3'd2);
    chk("mm16", 16, 0, 0, 0, 32, 1, 1, 0);
    run_n(1, 1'b1, 3'd0);
    chk("dec30", 17, 1, 1, 1, 30, 1, 1, 0);
    run_n(1, 1'b1, 3'd0);
    chk("dec28", 18, 2, 2, 2, 28, 1, 1, 0);
    run_n(1, 1'b1, 3'd0);
    chk("dec26", 19, 3, 3, 3, 26, 1, 1, 0);
    run_n(1, 1'b1, 3'd0);
    chk("dec24", 20, 4, 4, 4, 24, 1, 1, 0);
    run_n(1, 1'b1, 3'd0);
    chk("dec22", 21, 5, 5, 5, 22, 1, 0, 0);

    smp(1'b1, 1'b1, 3'd0, 1'b1);
    chk("clr_c", 0, 0, 0, 0, 0, 0, 0, 0);

    // Saturation at 255.
    run_n(254, 1'b1, 3'd0);
    chk("sat254", 254, 254, 254, 254, 0, 1, 0, 0);
    run_n(1, 1'b1, 3'd0);
    chk("sat255", 255, 255, 255, 255, 0, 1, 0, 0);
    run_n(45, 1'b1, 3'd0);
    chk("sat300", 255, 255, 255, 255, 0, 1, 0, 0);

    // Clear together with a valid sample drops that sample.
    smp(1'b1, 1'b1, 3'd0, 1'b1);
    run_n(10, 1'b1, 3'd0);
    chk("pre_clr", 10, 10, 10, 10, 0, 0, 0, 0);
    smp(1'b1, 1'b1, 3'd3, 1'b1);
    chk("clr_valid", 0, 0, 0, 0, 0, 0, 0, 0);
    smp(1'b0, 1'b1, 3'd0, 1'b0);
    chk("clr_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    run_n(1, 1'b1, 3'd0);
    chk("after_clr", 1, 1, 1, 1, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle with a sample in flight.
    run_n(2, 1'b1, 3'd0);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_sym      = 1'b1;
    bus.in_mismatch = 3'd0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    chk("arst", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("arst_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    smp(1'b0, 1'b0, 3'd0, 1'b0);
    chk("post_arst", 0, 0, 0, 0, 0, 0, 0, 0);

    // Consistency error and mismatch clamping.
    smp(1'b1, 1'b1, 3'd1, 1'b0);
    chk("err_set", 1, 1, 1, 1, 1, 0, 0, CHK);
    smp(1'b1, 1'b0, 3'd7, 1'b0);
    chk("clamp7", 2, 1, 0, 1, 5, 0, 0, CHK);
    smp(1'b1, 1'b0, 3'd5, 1'b0);
    chk("clamp5", 3, 1, 0, 1, 9, 0, 0, CHK);
    smp(1'b1, 1'b1, 3'd0, 1'b0);
    chk("err_sticky", 4, 2, 1, 1, 9, 0, 0, CHK);
    smp(1'b1, 1'b1, 3'd0, 1'b1);
    chk("err_clr", 0, 0, 0, 0, 0, 0, 0, 0);
    smp(1'b0, 1'b0, 3'd0, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    summary();
    $finish;
  end

endmodule
